multicycle_cu: RTL
==================

Name: multicycle_cu

Overview:
- Multi-cycle control unit for the small CPU datapath.
- Successor to the single-cycle opcode decoder:
  - sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states;
  - handshakes with a shared instruction/data memory;
  - adds branch, jump and halt opcodes, illegal-opcode trapping and a retired-instruction counter.
- Sits between the instruction register (IR) and the register file, ALU, PC and memory-port muxes.

Parameters:
- OP_W, 4, opcode width.
- ALU_OP_W, 3, alu_op width.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ins_op  in  OP_W  opcode field of the IR; valid from DECODE until the next FETCH.
- alu_zero  in  1  ALU zero flag; sampled in EXEC for beq.
- mem_ready  in  1  memory accepts or completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write (store).
- iord  out  1  memory address select: 0 = PC, 1 = ALU result.
- ir_wr_en  out  1  load IR.
- pc_wr_en  out  1  load PC.
- pc_src  out  2  PC source: 0 = PC+1, 1 = branch target, 2 = jump target.
- wr_en  out  1  register-file write.
- select0  out  1  ALU B operand: 0 = register, 1 = immediate.
- select1  out  1  writeback source: 0 = ALU, 1 = memory data.
- alu_op  out  ALU_OP_W  ALU operation.
- halted  out  1  core stopped.
- illegal_op  out  1  sticky undefined-opcode flag.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Opcodes:
  - 0 add: alu_op 000, select0 0.
  - 1 iadd: alu_op 001, select0 1.
  - 2 st: alu_op 010.
  - 3 ld: alu_op 011.
  - 4 beq: alu_op 100 (subtract).
  - 5 jmp.
  - 6 halt.
  - 7 to 2^OP_W-1: illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Outputs are combinational from state and op_q; no output is registered except halted, illegal_op and retired.
- Reset (asynchronous, any cycle, including mid-handshake):
  - state = IDLE, op_q = 0, retired = 0, halted = 0, illegal_op = 0.
  - All outputs are 0 in IDLE; mem_req drops immediately.
- IDLE -> FETCH unconditionally on the next edge.
- FETCH:
  - Drives mem_req = 1, iord = 0.
  - Holds while mem_ready = 0.
  - On mem_ready = 1: ir_wr_en = 1, pc_wr_en = 1, pc_src = 0; -> DECODE.
- DECODE:
  - Registers op_q <= ins_op.
  - halt -> HALT. Illegal -> HALT and sets illegal_op.
  - Otherwise -> EXEC.
- EXEC:
  - alu_op and select0 per op_q.
  - add, iadd, ld, st: alu_op/select0 as above. add/iadd -> WB; ld/st -> MEM.
  - beq: pc_src = 1; pc_wr_en = alu_zero (sampled this cycle); -> FETCH; retires.
  - jmp: pc_wr_en = 1, pc_src = 2, alu_op 000; -> FETCH; retires.
- MEM:
  - mem_req = 1, iord = 1, mem_we = (op_q == st).
  - Holds while mem_ready = 0; all outputs stable while waiting.
  - On ready: st -> FETCH and retires; ld -> WB.
- WB:
  - wr_en = 1; select1 = (op_q == ld); select0 = (op_q == iadd).
  - alu_op per op_q, held from EXEC.
  - -> FETCH; retires.
- HALT:
  - Absorbing; only reset leaves it.
  - halted = 1 registered on entry, visible from the cycle after DECODE.
  - No mem_req, wr_en or pc_wr_en while in HALT.
  - halt counts as retired; illegal does not.
- Counter: retired increments by 1 on each retire; wraps 2^CNT_W-1 -> 0.
- Minimum latencies with mem_ready held at 1:
  - add/iadd/st: 4 cycles.
  - ld: 5 cycles.
  - beq/jmp: 3 cycles.
- Any mem_ready outside FETCH or MEM is ignored.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_ADD..OP_HALT;
  - ALU_ADD/ALU_IADD/ALU_ST/ALU_LD/ALU_SUB codes;
  - PC_SRC_* constants;
  - state enum cu_state_t.
- One natural sub-module: cu_op_decode, a combinational map from op_q to alu_op, select0, select1, is_mem, is_store, is_branch, is_jump, is_halt, is_illegal. It is shared by DECODE and EXEC/WB.
- FSM and counter stay in multicycle_cu.

Test Plan:
- Reset then release with mem_ready = 1 and ins_op = 0 -> IDLE, FETCH, DECODE, EXEC, WB. wr_en = 1 only in WB, alu_op = 000, retired = 1 after 5 clocks from release.
- ins_op = 3 (ld), mem_ready low for 3 cycles in MEM -> mem_req = 1, iord = 1, mem_we = 0 held for 4 cycles. WB then has select1 = 1, wr_en = 1.
- ins_op = 4 with alu_zero = 1, then ins_op = 4 with alu_zero = 0 -> EXEC pc_wr_en = 1 with pc_src = 1, then pc_wr_en = 0. Both retire, retired = 2.
- ins_op = 9 -> HALT with illegal_op = 1 and halted = 1. retired is unchanged; no mem_req for 10 further cycles.
- Assert rst_n low mid-MEM of a st with mem_req high -> mem_req and mem_we = 0 immediately. After release: IDLE then FETCH, retired = 0.
- CNT_W = 4, run 16 add instructions -> retired counts to 15 then wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the small CPU control path: opcode and ALU codes,
// PC source selects and the multi-cycle control unit state encoding.
package cpu_pkg;

    localparam int unsigned CPU_OP_W     = 4;
    localparam int unsigned CPU_ALU_OP_W = 3;
    localparam int unsigned CPU_CNT_W    = 16;
    localparam int unsigned PC_SRC_W     = 2;

    // Opcodes; every encoding above OP_HALT is undefined
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_IADD = 4'd1;
    localparam logic [3:0] OP_ST   = 4'd2;
    localparam logic [3:0] OP_LD   = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd4;
    localparam logic [3:0] OP_JMP  = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd6;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_IADD = 3'd1;
    localparam logic [2:0] ALU_ST   = 3'd2;
    localparam logic [2:0] ALU_LD   = 3'd3;
    localparam logic [2:0] ALU_SUB  = 3'd4;

    // PC source selects
    localparam logic [PC_SRC_W-1:0] PC_SRC_INC = 2'd0;
    localparam logic [PC_SRC_W-1:0] PC_SRC_BR  = 2'd1;
    localparam logic [PC_SRC_W-1:0] PC_SRC_JMP = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } cu_state_t;

endpackage

// File: rtl/cu_op_decode.sv
// Combinational opcode classifier shared by the DECODE, EXEC, MEM and WB steps.
// Ports:
//   op          opcode to classify
//   alu_op      ALU operation for this opcode
//   select0     ALU B operand is the immediate
//   select1     writeback takes memory data
//   is_mem      opcode needs a MEM step (ld/st)
//   is_store    opcode is st
//   is_branch   opcode is beq
//   is_jump     opcode is jmp
//   is_halt     opcode is halt
//   is_illegal  opcode is undefined
module cu_op_decode #(
    parameter int unsigned OP_W     = 4,
    parameter int unsigned ALU_OP_W = 3
) (
    input  logic [OP_W-1:0]     op,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                select0,
    output logic                select1,
    output logic                is_mem,
    output logic                is_store,
    output logic                is_branch,
    output logic                is_jump,
    output logic                is_halt,
    output logic                is_illegal
);
    import cpu_pkg::*;

    // Opcode to control attributes
    always_comb begin
        alu_op     = ALU_OP_W'(ALU_ADD);
        select0    = 1'b0;
        select1    = 1'b0;
        is_mem     = 1'b0;
        is_store   = 1'b0;
        is_branch  = 1'b0;
        is_jump    = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_W'(OP_ADD):  alu_op = ALU_OP_W'(ALU_ADD);
            OP_W'(OP_IADD): begin
                alu_op  = ALU_OP_W'(ALU_IADD);
                select0 = 1'b1;
            end
            OP_W'(OP_ST): begin
                alu_op   = ALU_OP_W'(ALU_ST);
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OP_W'(OP_LD): begin
                alu_op  = ALU_OP_W'(ALU_LD);
                is_mem  = 1'b1;
                select1 = 1'b1;
            end
            OP_W'(OP_BEQ): begin
                alu_op    = ALU_OP_W'(ALU_SUB);
                is_branch = 1'b1;
            end
            OP_W'(OP_JMP):  is_jump = 1'b1;
            OP_W'(OP_HALT): is_halt = 1'b1;
            default:        is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: walks each instruction through FETCH, DECODE,
// EXEC, MEM and WB, handshaking with a shared instruction/data memory.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ins_op            IR opcode field (valid from DECODE until the next FETCH)
//   alu_zero          ALU zero flag, used by beq in EXEC
//   mem_ready         memory accepts/completes the request this cycle
//   mem_req, mem_we   memory request and write strobe
//   iord              memory address select (0 = PC, 1 = ALU result)
//   ir_wr_en          load IR
//   pc_wr_en, pc_src  load PC and its source (PC+1 / branch / jump)
//   wr_en             register-file write
//   select0, select1  ALU B operand select, writeback source select
//   alu_op            ALU operation
//   halted            core stopped (registered)
//   illegal_op        sticky undefined-opcode flag (registered)
//   retired           retired-instruction count (registered, wraps)
module multicycle_cu
    import cpu_pkg::*;
#(
    parameter int unsigned OP_W     = CPU_OP_W,
    parameter int unsigned ALU_OP_W = CPU_ALU_OP_W,
    parameter int unsigned CNT_W    = CPU_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OP_W-1:0]     ins_op,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_wr_en,
    output logic                pc_wr_en,
    output logic [1:0]          pc_src,
    output logic                wr_en,
    output logic                select0,
    output logic                select1,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                halted,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    retired
);

    cu_state_t            state;
    cu_state_t            state_nxt;
    logic [OP_W-1:0]      op_q;
    logic [OP_W-1:0]      dec_op;
    logic                 retire_c;
    logic                 enter_halt_c;

    logic [ALU_OP_W-1:0]  d_alu_op;
    logic                 d_select0;
    logic                 d_select1;
    logic                 d_is_mem;
    logic                 d_is_store;
    logic                 d_is_branch;
    logic                 d_is_jump;
    logic                 d_is_halt;
    logic                 d_is_illegal;

    // DECODE classifies the live IR field; later steps use the captured opcode
    assign dec_op = (state == ST_DECODE) ? ins_op : op_q;

    cu_op_decode #(
        .OP_W     (OP_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_dec (
        .op         (dec_op),
        .alu_op     (d_alu_op),
        .select0    (d_select0),
        .select1    (d_select1),
        .is_mem     (d_is_mem),
        .is_store   (d_is_store),
        .is_branch  (d_is_branch),
        .is_jump    (d_is_jump),
        .is_halt    (d_is_halt),
        .is_illegal (d_is_illegal)
    );

    // State and captured opcode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_DECODE) begin
                op_q <= ins_op;
            end
        end
    end

    // Next state and combinational control outputs
    always_comb begin
        state_nxt    = state;
        retire_c     = 1'b0;
        enter_halt_c = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        iord         = 1'b0;
        ir_wr_en     = 1'b0;
        pc_wr_en     = 1'b0;
        pc_src       = PC_SRC_INC;
        wr_en        = 1'b0;
        select0      = 1'b0;
        select1      = 1'b0;
        alu_op       = '0;
        case (state)
            ST_IDLE: state_nxt = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_wr_en  = 1'b1;
                    pc_wr_en  = 1'b1;
                    pc_src    = PC_SRC_INC;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (d_is_halt || d_is_illegal) begin
                    enter_halt_c = 1'b1;
                    retire_c     = d_is_halt;
                    state_nxt    = ST_HALT;
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op  = d_alu_op;
                select0 = d_select0;
                if (d_is_branch) begin
                    pc_src    = PC_SRC_BR;
                    pc_wr_en  = alu_zero;
                    retire_c  = 1'b1;
                    state_nxt = ST_FETCH;
                end else if (d_is_jump) begin
                    pc_src    = PC_SRC_JMP;
                    pc_wr_en  = 1'b1;
                    retire_c  = 1'b1;
                    state_nxt = ST_FETCH;
                end else if (d_is_mem) begin
                    state_nxt = ST_MEM;
                end else begin
                    state_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                // ALU keeps producing the address while the memory stalls
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = d_is_store;
                alu_op  = d_alu_op;
                select0 = d_select0;
                if (mem_ready) begin
                    if (d_is_store) begin
                        retire_c  = 1'b1;
                        state_nxt = ST_FETCH;
                    end else begin
                        state_nxt = ST_WB;
                    end
                end
            end
            ST_WB: begin
                wr_en     = 1'b1;
                select1   = d_select1;
                select0   = d_select0;
                alu_op    = d_alu_op;
                retire_c  = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sticky status flags, set as DECODE hands over to HALT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted     <= 1'b0;
            illegal_op <= 1'b0;
        end else if (enter_halt_c) begin
            halted     <= 1'b1;
            illegal_op <= illegal_op | d_is_illegal;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (retire_c) begin
            retired <= retired + CNT_W'(1);
        end
    end

endmodule
